// File: rtl/matrix_mul_add_seq_pkg.sv
// matrix_mul_add_seq_pkg
//   Shared definitions for the multiply-add sequencer and its lane set:
//   the lane width, the sequencer state encoding and the lane slice helper.
package matrix_mul_add_seq_pkg;

  localparam int unsigned LANE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Low bit of lane i inside a packed row vector ([i*LANE_W +: LANE_W]).
  function automatic int unsigned lane_lo(input int unsigned i);
    return i * LANE_W;
  endfunction

endpackage

// File: rtl/matrix_mul_add_seq_set.sv
// MatrixMulAddSet
//   Parallel 16-bit multiply-add lane set (combinational).
//   Every lane computes resultSet[i] = (mulaSet * mulbSet[i]) + addcSet[i],
//   with the product truncated to 16 bits and the sum taken mod 2^16.
// Ports:
//   mulaSet   : scalar multiplicand broadcast to all lanes
//   mulbSet   : per-lane multiplicands, lane i at [i*16 +: 16]
//   addcSet   : per-lane addends, same packing
//   resultSet : per-lane results, same packing
module MatrixMulAddSet
  import matrix_mul_add_seq_pkg::*;
#(
  parameter int unsigned PARALLEL_NUM = 28
) (
  input  logic [LANE_W-1:0]              mulaSet,
  input  logic [PARALLEL_NUM*LANE_W-1:0] mulbSet,
  input  logic [PARALLEL_NUM*LANE_W-1:0] addcSet,
  output logic [PARALLEL_NUM*LANE_W-1:0] resultSet
);

  logic [2*LANE_W-1:0] prod;

  always_comb begin
    resultSet = '0;
    prod      = '0;
    for (int unsigned i = 0; i < PARALLEL_NUM; i++) begin
      prod = {{LANE_W{1'b0}}, mulaSet} * {{LANE_W{1'b0}}, mulbSet[lane_lo(i) +: LANE_W]};
      resultSet[lane_lo(i) +: LANE_W] = prod[LANE_W-1:0] + addcSet[lane_lo(i) +: LANE_W];
    end
  end

endmodule

// File: rtl/matrix_mul_add_seq.sv
// matrix_mul_add_seq
//   Sequencing initiator for the multiply-add lane set. For each output row
//   it streams k_len (A scalar, B row) pairs, accumulating
//   Y[r][:] += A[r][k] * B[k][:] (mod 2^16 per lane), then presents the row
//   on a valid/ready stream. Repeats for row_cnt rows, then pulses done.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   start, k_len, row_cnt      : job start and configuration (IDLE only)
//   busy, done                 : job status; done is a one-cycle pulse
//   a_valid/a_data/a_ready     : A scalar stream
//   b_valid/b_data/b_ready     : B row stream (consumed jointly with A)
//   y_valid/y_data/y_last/y_ready : result row stream
module matrix_mul_add_seq
  import matrix_mul_add_seq_pkg::*;
#(
  parameter int unsigned PARALLEL_NUM = 28,
  parameter int unsigned K_W          = 8,
  parameter int unsigned R_W          = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [K_W-1:0]                 k_len,
  input  logic [R_W-1:0]                 row_cnt,
  output logic                           busy,
  output logic                           done,
  input  logic                           a_valid,
  input  logic [LANE_W-1:0]              a_data,
  output logic                           a_ready,
  input  logic                           b_valid,
  input  logic [PARALLEL_NUM*LANE_W-1:0] b_data,
  output logic                           b_ready,
  output logic                           y_valid,
  output logic [PARALLEL_NUM*LANE_W-1:0] y_data,
  output logic                           y_last,
  input  logic                           y_ready
);

  localparam int unsigned   ROW_W = PARALLEL_NUM * LANE_W;
  localparam logic [K_W-1:0] K_ONE = K_W'(1);
  localparam logic [R_W-1:0] R_ONE = R_W'(1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] acc_q, acc_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [K_W-1:0]   klen_q, klen_d;
  logic [R_W-1:0]   rows_q, rows_d;

  logic [ROW_W-1:0] set_result;
  logic             fire;
  logic             last_row;

  MatrixMulAddSet #(
    .PARALLEL_NUM(PARALLEL_NUM)
  ) u_set (
    .mulaSet  (a_data),
    .mulbSet  (b_data),
    .addcSet  (acc_q),
    .resultSet(set_result)
  );

  // A and B are only ever consumed together, and only while accumulating.
  assign fire     = (state_q == ST_ACC) && a_valid && b_valid;
  assign last_row = (r_q == (rows_q - R_ONE));

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign a_ready = fire;
  assign b_ready = fire;
  assign y_valid = (state_q == ST_OUT);
  assign y_data  = y_valid ? acc_q : '0;
  assign y_last  = y_valid && last_row;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    r_d     = r_q;
    klen_d  = klen_q;
    rows_d  = rows_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((k_len != '0) && (row_cnt != '0)) begin
            klen_d  = k_len;
            rows_d  = row_cnt;
            acc_d   = '0;
            k_d     = '0;
            r_d     = '0;
            state_d = ST_ACC;
          end else begin
            // Empty job: finish without touching any stream.
            state_d = ST_DONE;
          end
        end
      end
      ST_ACC: begin
        if (fire) begin
          acc_d = set_result;
          if (k_q == (klen_q - K_ONE)) begin
            state_d = ST_OUT;
          end else begin
            k_d = k_q + K_ONE;
          end
        end
      end
      ST_OUT: begin
        if (y_ready) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            acc_d   = '0;
            k_d     = '0;
            r_d     = r_q + R_ONE;
            state_d = ST_ACC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      r_q     <= '0;
      klen_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      r_q     <= r_d;
      klen_q  <= klen_d;
      rows_q  <= rows_d;
    end
  end

endmodule

// File: tb/tb_matrix_mul_add_seq.sv
// tb_matrix_mul_add_seq
//   Directed bench for matrix_mul_add_seq with four lanes. Inputs change on
//   the falling edge; outputs are sampled on the falling edge (or 1ns after
//   an input change for the combinational ready outputs).
module tb_matrix_mul_add_seq;

  localparam int PN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    k_len = '0;
  logic [7:0]    row_cnt = '0;
  logic          busy, done;
  logic          a_valid = 1'b0;
  logic [15:0]   a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [PN*16-1:0] b_data = '0;
  logic          b_ready;
  logic          y_valid;
  logic [PN*16-1:0] y_data;
  logic          y_last;
  logic          y_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matrix_mul_add_seq #(
    .PARALLEL_NUM(PN),
    .K_W(8),
    .R_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .row_cnt(row_cnt),
    .busy(busy), .done(done),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready)
  );

  task automatic start_job(input logic [7:0] k, input logic [7:0] r);
    k_len = k; row_cnt = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fire_step(input logic [15:0] a, input logic [PN*16-1:0] b);
    a_valid = 1'b1; b_valid = 1'b1; a_data = a; b_data = b;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    #2;
    n_cmp++; if ({busy, done, a_ready, b_ready, y_valid, y_last} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 000000", {busy, done, a_ready, b_ready, y_valid, y_last}); end
    n_cmp++; if (y_data !== '0) begin
      n_err++; $display("FAIL reset_ydata: got %h want 0", y_data); end
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    start_job(8'd1, 8'd1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    a_valid = 1'b1; b_valid = 1'b1; a_data = 16'd3;
    b_data = {16'd4, 16'd3, 16'd2, 16'd1};
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b11) begin
      n_err++; $display("FAIL single_ready: got %b want 11", {a_ready, b_ready}); end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    n_cmp++; if (y_valid !== 1'b1 || y_last !== 1'b1) begin
      n_err++; $display("FAIL single_yvalid_last: got %b%b want 11", y_valid, y_last); end
    n_cmp++; if (y_data !== {16'd12, 16'd9, 16'd6, 16'd3}) begin
      n_err++; $display("FAIL single_ydata: got %h want 000c000900060003", y_data); end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || y_valid !== 1'b0) begin
      n_err++; $display("FAIL single_done: got done=%b busy=%b yv=%b want 1 1 0", done, busy, y_valid); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_two_rows();
    start_job(8'd3, 8'd2);
    fire_step(16'd2, {PN{16'd1}});
    fire_step(16'd3, {PN{16'd1}});
    fire_step(16'd4, {PN{16'd1}});
    n_cmp++; if (y_valid !== 1'b1 || y_last !== 1'b0 || y_data !== {PN{16'd9}}) begin
      n_err++; $display("FAIL rows_r0: got v=%b l=%b d=%h want 1 0 {4{0009}}", y_valid, y_last, y_data); end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    n_cmp++; if (y_valid !== 1'b0 || busy !== 1'b1 || y_data !== '0) begin
      n_err++; $display("FAIL rows_gap: got v=%b busy=%b d=%h want 0 1 0", y_valid, busy, y_data); end
    fire_step(16'd1, {PN{16'd5}});
    fire_step(16'd1, {PN{16'd5}});
    fire_step(16'd1, {PN{16'd5}});
    n_cmp++; if (y_valid !== 1'b1 || y_last !== 1'b1 || y_data !== {PN{16'd15}}) begin
      n_err++; $display("FAIL rows_r1: got v=%b l=%b d=%h want 1 1 {4{000f}}", y_valid, y_last, y_data); end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rows_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    start_job(8'd2, 8'd1);
    fire_step(16'hFFFF, {PN{16'd1}});
    fire_step(16'hFFFF, {PN{16'd1}});
    n_cmp++; if (y_valid !== 1'b1 || y_data !== {PN{16'hFFFE}}) begin
      n_err++; $display("FAIL wrap_sum: got v=%b d=%h want 1 {4{fffe}}", y_valid, y_data); end
    y_ready = 1'b1; @(negedge clk); y_ready = 1'b0; @(negedge clk);
    start_job(8'd1, 8'd1);
    fire_step(16'h0100, {PN{16'h0100}});
    n_cmp++; if (y_valid !== 1'b1 || y_data !== '0) begin
      n_err++; $display("FAIL wrap_prod: got v=%b d=%h want 1 0", y_valid, y_data); end
    y_ready = 1'b1; @(negedge clk); y_ready = 1'b0; @(negedge clk);
  endtask

  task automatic test_bubbles();
    start_job(8'd2, 8'd1);
    b_valid = 1'b1; a_valid = 1'b0; b_data = {PN{16'd7}}; a_data = 16'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({a_ready, b_ready} !== 2'b00 || y_valid !== 1'b0) begin
        n_err++; $display("FAIL bubble_%0d: got rdy=%b yv=%b want 00 0", i, {a_ready, b_ready}, y_valid); end
      @(negedge clk);
    end
    b_valid = 1'b0;
    fire_step(16'd2, {PN{16'd3}});
    fire_step(16'd2, {PN{16'd3}});
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (y_valid !== 1'b1 || y_data !== {PN{16'd12}} || a_ready !== 1'b0 || b_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_%0d: got v=%b d=%h ar=%b br=%b want 1 {4{000c}} 0 0", i, y_valid, y_data, a_ready, b_ready); end
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    y_ready = 1'b1; @(negedge clk); y_ready = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    a_valid = 1'b1; b_valid = 1'b1;
    start_job(8'd0, 8'd3);
    #1;
    n_cmp++; if (done !== 1'b1 || y_valid !== 1'b0 || a_ready !== 1'b0) begin
      n_err++; $display("FAIL zero_k: got done=%b yv=%b ar=%b want 1 0 0", done, y_valid, a_ready); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || y_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_k_end: got done=%b busy=%b yv=%b want 0 0 0", done, busy, y_valid); end
    start_job(8'd2, 8'd0);
    n_cmp++; if (done !== 1'b1 || y_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_r: got done=%b yv=%b want 1 0", done, y_valid); end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    start_job(8'd1, 8'd1);
    start_job(8'd0, 8'd0);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL busy_start: got busy=%b done=%b want 1 0", busy, done); end
    fire_step(16'd5, {PN{16'd1}});
    n_cmp++; if (y_valid !== 1'b1 || y_last !== 1'b1 || y_data !== {PN{16'd5}}) begin
      n_err++; $display("FAIL busy_cfg: got v=%b l=%b d=%h want 1 1 {4{0005}}", y_valid, y_last, y_data); end
    y_ready = 1'b1; @(negedge clk); y_ready = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_job(8'd3, 8'd1);
    fire_step(16'd7, {PN{16'd7}});
    fire_step(16'd7, {PN{16'd7}});
    a_valid = 1'b1; b_valid = 1'b1; a_data = 16'd7; y_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, a_ready, b_ready, y_valid, y_last} !== 6'b0 || y_data !== '0) begin
      n_err++; $display("FAIL midreset: got flags=%b d=%h want 000000 0", {busy, done, a_ready, b_ready, y_valid, y_last}, y_data); end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midreset_idle: got busy=%b done=%b want 0 0", busy, done); end
    start_job(8'd1, 8'd1);
    fire_step(16'd2, {PN{16'd3}});
    n_cmp++; if (y_valid !== 1'b1 || y_last !== 1'b1 || y_data !== {PN{16'd6}}) begin
      n_err++; $display("FAIL midreset_new: got v=%b l=%b d=%h want 1 1 {4{0006}}", y_valid, y_last, y_data); end
    y_ready = 1'b1; @(negedge clk); y_ready = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL midreset_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_two_rows();
    test_wrap();
    test_bubbles();
    test_zero_len();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
